resonator_bank: RTL
===================

Name: resonator_bank

Overview:
- Time-multiplexed bank of CHANNELS damped mass-spring resonators for the percussive voice path. Generalises the single resonator with parametrised widths, shifts and channel count, plus per-channel tension.
- Adds a channel sequencer with busy/done status, per-channel trigger and mute, update-overrun reporting, and a registered mix output.
- Sits between the trigger decoder and the audio mixer. One update pulse advances every channel by one audio tick.

Parameters:
CHANNELS, 4, number of resonators (1..16)
XW, 12, position/sample width
VW, 16, velocity width
LW, 3, trigger level width (LW <= XW-2)
TW, 4, tension width
X_SHIFT, 4, position-to-velocity coupling shift
V_SHIFT, 10, velocity-to-position coupling shift
DAMP_LIGHT, 11, normal damping shift
DAMP_HEAVY, 9, near-rest damping shift

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
trig_valid  in  1  load trigger this cycle
trig_ch  in  clog2(CHANNELS)  target channel
trig_level  in  LW  strike level; 0 = mute
update  in  1  audio tick request, single-cycle pulse
tension  in  CHANNELS*TW  per-channel tension, channel n at [n*TW +: TW]
sample  out  CHANNELS*XW  per-channel position x, signed, direct from state registers
mix  out  XW+clog2(CHANNELS)  signed sum of all x, registered
busy  out  1  sequencer active
done  out  1  one-cycle pulse when tick complete
overrun  out  1  one-cycle pulse when update arrives while busy

Behaviour:
- Reset (clk edge with rst=1):
  - all v, x, mix = 0; state IDLE; busy, done, overrun = 0; channel index and step counter = 0.
  - Reset mid-tick aborts the tick with no done pulse.
- Trigger (any state):
  - Channel trig_ch is loaded with v=0 and x={1'b0, trig_level, (XW-1-LW) ones}.
  - If trig_level=0: x=0, v=0 (mute).
  - A trigger overrides any sequencer write to the same channel in that cycle.
  - If the target is the channel currently being processed, its remaining steps are abandoned and the sequencer moves to the next channel (or finishes) on the following edge.
  - trig_ch >= CHANNELS is ignored.
- Sequencer FSM, states IDLE, DAMP, VSTEP, XSTEP:
  - IDLE: when update=1, set ch=0 and go to DAMP; busy goes high the next cycle.
  - DAMP, for channel ch:
    - "quiet" means v[VW-1:VW-3] all equal AND x[XW-1:XW-3] all equal.
    - If quiet: v <= v - (v>>>DAMP_HEAVY); otherwise v <= v - (v>>>DAMP_LIGHT).
    - cnt <= tension[ch].
    - Next state: VSTEP if tension>1, XSTEP if tension=1, else advance.
  - VSTEP: v <= sat_VW(v - (x>>>X_SHIFT)); cnt--. Stay in VSTEP while cnt>2 before the decrement; otherwise go to XSTEP. Result: exactly tension-1 VSTEP cycles.
  - XSTEP: x <= sat_XW(x + (v>>>V_SHIFT)); then advance.
  - Advance: if ch=CHANNELS-1, go to IDLE, pulse done and register mix; else ch++ and go to DAMP.
- Cycles per channel: 1 if tension=0, otherwise tension+1. done rises sum-of-cycles edges after busy rises.
- Tension is sampled per channel in its DAMP cycle, so changes mid-tick affect only channels not yet started.
- Arithmetic:
  - Compute at width+1, arithmetic shifts, two's complement.
  - Saturation clamps to the max positive or min negative value when the top two bits of the extended result differ; results never wrap.
  - Damping itself cannot overflow.
- update while busy: ignored; overrun pulses for one cycle. update in the same cycle done is asserted (state IDLE) is accepted normally.
- mix: signed sum of all x, computed from post-tick values, registered on the done cycle. Holds between ticks and does not track triggers.

Test Plan:
- Reset, then trigger ch0 level 3 -> sample[ch0]=0x3FF, v=0; mix stays 0 until the first done.
- Defaults, ch0 x=0x3FF, v=0, tension0=2, others 0, one update:
  - ch0 is light-damped (x top bits 001), then VSTEP gives v=-63 (0xFFC1), then XSTEP gives x=0x3FE.
  - done pulses 6 cycles after busy rises (3+1+1+1).
  - mix = 0x3FE.
- Tensions {0,1,2,15}, one update -> done 22 cycles after busy rises. A second update at cycle 5 -> overrun pulse, no extra tick.
- Trigger level 0 on the channel in VSTEP -> that channel reads x=0, v=0. The sequencer moves to the next channel and total latency shrinks accordingly.
- Trigger level 7 (x=0x7FF), tension 15, repeated updates:
  - v clamps at 0x8000 and never wraps positive.
  - x never wraps past 0x7FF or 0x800.
  - Once near rest, DAMP_HEAVY is selected and amplitude decays monotonically toward 0.
- Assert rst mid-VSTEP -> next cycle all samples 0, busy=0, no done pulse. The next update runs a full tick.

Source files
------------

// File: rtl/resonator_bank_if.sv
// Control and status bundle for the resonator bank: trigger and tick requests
// in, per-channel samples, registered mix and sequencer status out.
interface resonator_bank_if #(
    parameter int CHANNELS = 4,
    parameter int XW       = 12,
    parameter int LW       = 3,
    parameter int TW       = 4
);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int MW = XW + $clog2(CHANNELS);

    logic                   trig_valid;
    logic [CW-1:0]          trig_ch;
    logic [LW-1:0]          trig_level;
    logic                   update;
    logic [CHANNELS*TW-1:0] tension;
    logic [CHANNELS*XW-1:0] sample;
    logic [MW-1:0]          mix;
    logic                   busy;
    logic                   done;
    logic                   overrun;

    modport master (
        output trig_valid, trig_ch, trig_level, update, tension,
        input  sample, mix, busy, done, overrun
    );

    modport slave (
        input  trig_valid, trig_ch, trig_level, update, tension,
        output sample, mix, busy, done, overrun
    );
endinterface

// File: rtl/resonator_bank.sv
// Time-multiplexed bank of damped mass-spring resonators. One shared datapath
// walks the channels in order on every update tick: damp velocity, apply
// tension-many coupling steps, then move the position. Triggers load a channel
// directly at any time and take priority over the sequencer.
module resonator_bank #(
    parameter int CHANNELS   = 4,
    parameter int XW         = 12,
    parameter int VW         = 16,
    parameter int LW         = 3,
    parameter int TW         = 4,
    parameter int X_SHIFT    = 4,
    parameter int V_SHIFT    = 10,
    parameter int DAMP_LIGHT = 11,
    parameter int DAMP_HEAVY = 9
) (
    input logic             clk,
    input logic             rst,
    resonator_bank_if.slave bus
);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int MW = XW + $clog2(CHANNELS);
    localparam int SW = ((XW > VW) ? XW : VW) + 2;

    localparam logic signed [SW-1:0] V_MAX = {{(SW-VW+1){1'b0}}, {(VW-1){1'b1}}};
    localparam logic signed [SW-1:0] V_MIN = ~V_MAX;
    localparam logic signed [SW-1:0] X_MAX = {{(SW-XW+1){1'b0}}, {(XW-1){1'b1}}};
    localparam logic signed [SW-1:0] X_MIN = ~X_MAX;

    typedef enum logic [1:0] {IDLE, DAMP, VSTEP, XSTEP} state_t;

    state_t                 state, state_nxt;
    logic [CW-1:0]          ch, ch_nxt;
    logic [TW-1:0]          cnt, cnt_nxt;
    logic                   done_reg, done_nxt;
    logic                   overrun_reg, overrun_nxt;
    logic                   advance;
    logic signed [MW-1:0]   mix_reg, mix_sum, x_ext;

    logic signed [VW-1:0]   v_reg [CHANNELS];
    logic signed [XW-1:0]   x_reg [CHANNELS];
    logic signed [VW-1:0]   v_nxt [CHANNELS];
    logic signed [XW-1:0]   x_nxt [CHANNELS];

    logic signed [VW-1:0]   v_cur, v_new, v_damp, v_step;
    logic signed [XW-1:0]   x_cur, x_new, x_step;
    logic [TW-1:0]          ten_cur;
    logic signed [SW-1:0]   v_w, x_w, v_damp_w, v_step_w, x_step_w;
    logic                   quiet;
    logic                   seq_v_we, seq_x_we;
    logic                   trig_hit;
    logic [XW-1:0]          x_load;

    function automatic logic signed [VW-1:0] sat_v(input logic signed [SW-1:0] a);
        if (a > V_MAX)      sat_v = V_MAX[VW-1:0];
        else if (a < V_MIN) sat_v = V_MIN[VW-1:0];
        else                sat_v = a[VW-1:0];
    endfunction

    function automatic logic signed [XW-1:0] sat_x(input logic signed [SW-1:0] a);
        if (a > X_MAX)      sat_x = X_MAX[XW-1:0];
        else if (a < X_MIN) sat_x = X_MIN[XW-1:0];
        else                sat_x = a[XW-1:0];
    endfunction

    // Shared datapath: damping, velocity step and position step for the active channel
    always_comb begin
        v_cur    = v_reg[ch];
        x_cur    = x_reg[ch];
        ten_cur  = bus.tension[ch*TW +: TW];
        v_w      = v_cur;
        x_w      = x_cur;
        quiet    = ((&v_cur[VW-1:VW-3]) | ~(|v_cur[VW-1:VW-3])) &
                   ((&x_cur[XW-1:XW-3]) | ~(|x_cur[XW-1:XW-3]));
        v_damp_w = v_w - (v_w >>> (quiet ? DAMP_HEAVY : DAMP_LIGHT));
        v_damp   = v_damp_w[VW-1:0];
        v_step_w = v_w - (x_w >>> X_SHIFT);
        v_step   = sat_v(v_step_w);
        x_step_w = x_w + (v_w >>> V_SHIFT);
        x_step   = sat_x(x_step_w);
    end

    // Trigger decode: out-of-range channels never hit, level 0 loads silence
    always_comb begin
        trig_hit = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (bus.trig_valid && bus.trig_ch == CW'(i)) trig_hit = 1'b1;
        end
        if (bus.trig_level == '0) x_load = '0;
        else                      x_load = {1'b0, bus.trig_level, {(XW-1-LW){1'b1}}};
    end

    // Sequencer next-state: per-channel step ordering, abort on retrigger, tick completion
    always_comb begin
        state_nxt   = state;
        ch_nxt      = ch;
        cnt_nxt     = cnt;
        done_nxt    = 1'b0;
        overrun_nxt = bus.update && (state != IDLE);
        advance     = 1'b0;
        seq_v_we    = 1'b0;
        seq_x_we    = 1'b0;
        v_new       = v_cur;
        x_new       = x_cur;
        case (state)
            IDLE: begin
                if (bus.update) begin
                    ch_nxt    = '0;
                    state_nxt = DAMP;
                end
            end
            DAMP: begin
                seq_v_we = 1'b1;
                v_new    = v_damp;
                cnt_nxt  = ten_cur;
                if (ten_cur > TW'(1))       state_nxt = VSTEP;
                else if (ten_cur == TW'(1)) state_nxt = XSTEP;
                else                        advance   = 1'b1;
            end
            VSTEP: begin
                seq_v_we  = 1'b1;
                v_new     = v_step;
                cnt_nxt   = cnt - TW'(1);
                state_nxt = (cnt > TW'(2)) ? VSTEP : XSTEP;
            end
            XSTEP: begin
                seq_x_we = 1'b1;
                x_new    = x_step;
                advance  = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
        if (state != IDLE && trig_hit && bus.trig_ch == ch) advance = 1'b1;
        if (advance) begin
            if (ch == CW'(CHANNELS-1)) begin
                state_nxt = IDLE;
                done_nxt  = 1'b1;
            end else begin
                ch_nxt    = ch + CW'(1);
                state_nxt = DAMP;
            end
        end
    end

    // Per-channel next values: sequencer write first, trigger load wins
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            v_nxt[i] = v_reg[i];
            x_nxt[i] = x_reg[i];
            if (state != IDLE && ch == CW'(i)) begin
                if (seq_v_we) v_nxt[i] = v_new;
                if (seq_x_we) x_nxt[i] = x_new;
            end
            if (trig_hit && bus.trig_ch == CW'(i)) begin
                v_nxt[i] = '0;
                x_nxt[i] = x_load;
            end
        end
    end

    // Mix of post-tick positions, captured only when the tick completes
    always_comb begin
        mix_sum = '0;
        x_ext   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            x_ext   = x_nxt[i];
            mix_sum = mix_sum + x_ext;
        end
    end

    // Sequencer and status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ch          <= '0;
            cnt         <= '0;
            done_reg    <= 1'b0;
            overrun_reg <= 1'b0;
            mix_reg     <= '0;
        end else begin
            state       <= state_nxt;
            ch          <= ch_nxt;
            cnt         <= cnt_nxt;
            done_reg    <= done_nxt;
            overrun_reg <= overrun_nxt;
            if (done_nxt) mix_reg <= mix_sum;
        end
    end

    // Resonator state registers for every channel
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                v_reg[i] <= '0;
                x_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                v_reg[i] <= v_nxt[i];
                x_reg[i] <= x_nxt[i];
            end
        end
    end

    // Output packing: samples straight from the position registers
    always_comb begin
        bus.sample = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            bus.sample[i*XW +: XW] = x_reg[i];
        end
    end

    assign bus.mix     = mix_reg;
    assign bus.busy    = (state != IDLE);
    assign bus.done    = done_reg;
    assign bus.overrun = overrun_reg;
endmodule
